// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - shared types and counter helper for the gshare predictor
package gshare_predictor_pkg;

    // Two-bit saturating direction counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } pht_ctr_t;

    localparam int GSHARE_GHR_BITS = 8;

    // Next counter state after a resolved outcome; saturates at both ends.
    function automatic pht_ctr_t pht_next(pht_ctr_t c, logic taken);
        pht_ctr_t n;
        case (c)
            STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
            default:   n = taken ? STRONG_T : WEAK_T;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - pattern history table: flop array of 2-bit counters
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   rd_idx, rd_ctr  asynchronous lookup port (returns the pre-update value)
//   wr_en, wr_idx,  training port: the addressed counter steps toward
//   wr_taken        wr_taken on the next rising edge
module gshare_pht
    import gshare_predictor_pkg::*;
#(
    parameter int         IDX_W    = GSHARE_GHR_BITS,
    parameter logic [1:0] INIT_CTR = 2'b10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    pht_ctr_t pht [ENTRIES];

    // No write-to-read bypass: a lookup in the same cycle as a training
    // write to the same entry sees the old counter.
    assign rd_ctr = pht[rd_idx];

    // Training is a read-modify-write of a single entry, so the whole
    // saturating step lives here next to the storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= pht_ctr_t'(INIT_CTR);
            end
        end else if (wr_en) begin
            pht[wr_idx] <= pht_next(pht[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare conditional-branch predictor with history repair
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fetch_pc          PC of the instruction in IF
//   fetch_is_branch   instruction in IF is a conditional branch
//   fetch_stall       IF held this cycle; speculative history does not shift
//   prediction        combinational taken prediction for fetch_pc
//   ex_valid          a conditional branch resolves in EX this cycle
//   ex_pc, ex_taken   PC and actual outcome of the resolving branch
//   ex_mispredict     the resolving branch was mispredicted (needs ex_valid)
//   branch_cnt        saturating count of resolved conditional branches
//   mispredict_cnt    saturating count of resolved mispredictions
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int         GHR_BITS = GSHARE_GHR_BITS,
    parameter logic [1:0] INIT_CTR = 2'b10,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      fetch_pc,
    input  logic             fetch_is_branch,
    input  logic             fetch_stall,
    output logic             prediction,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int               PHT_ENTRIES = 2 ** GHR_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // ghr_spec runs ahead with predicted outcomes at fetch; ghr_arch only
    // ever contains resolved outcomes and is the repair source.
    logic [GHR_BITS-1:0] ghr_spec;
    logic [GHR_BITS-1:0] ghr_arch;
    logic [GHR_BITS-1:0] ghr_arch_next;

    logic [GHR_BITS-1:0] idx_f;
    logic [GHR_BITS-1:0] idx_e;
    logic [1:0]          rd_ctr;
    logic                recover;
    logic                spec_shift;

    // Word-aligned PC bits hashed with history; lookup uses the speculative
    // history, training uses the history the branch was predicted with
    // once resolved in order, i.e. the architectural one.
    assign idx_f = fetch_pc[GHR_BITS+1:2] ^ ghr_spec;
    assign idx_e = ex_pc[GHR_BITS+1:2] ^ ghr_arch;

    gshare_pht #(
        .IDX_W    (GHR_BITS),
        .INIT_CTR (INIT_CTR)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_f),
        .rd_ctr   (rd_ctr),
        .wr_en    (ex_valid),
        .wr_idx   (idx_e),
        .wr_taken (ex_taken)
    );

    assign prediction = fetch_is_branch & rd_ctr[1];

    assign ghr_arch_next = {ghr_arch[GHR_BITS-2:0], ex_taken};

    // A mispredict makes whatever is in fetch wrong-path, so recovery wins
    // over the speculative shift of the same cycle.
    assign recover    = ex_valid & ex_mispredict;
    assign spec_shift = fetch_is_branch & ~fetch_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_spec <= '0;
            ghr_arch <= '0;
        end else begin
            if (ex_valid) begin
                ghr_arch <= ghr_arch_next;
            end
            if (recover) begin
                ghr_spec <= ghr_arch_next;
            end else if (spec_shift) begin
                ghr_spec <= {ghr_spec[GHR_BITS-2:0], prediction};
            end
        end
    end

    // Performance counters stick at all-ones rather than wrapping so a long
    // run never reports a misleadingly small value.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (ex_valid) begin
            if (!(&branch_cnt)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (ex_mispredict && !(&mispredict_cnt)) begin
                mispredict_cnt <= mispredict_cnt + CNT_ONE;
            end
        end
    end

    // PC bits outside the hash window and the counter's hysteresis bit do
    // not participate in the prediction.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[31:GHR_BITS+2], fetch_pc[1:0],
                           ex_pc[31:GHR_BITS+2], ex_pc[1:0], rd_ctr[0],
                           PHT_ENTRIES[0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_is_branch;
    logic        fetch_stall;
    logic        prediction;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    logic        s_prediction;
    logic [1:0]  s_branch_cnt;
    logic [1:0]  s_mispredict_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int     m_pht [256];
    int     m_gs;
    int     m_ga;
    longint m_bc;
    longint m_mc;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_pc        (fetch_pc),
        .fetch_is_branch (fetch_is_branch),
        .fetch_stall     (fetch_stall),
        .prediction      (prediction),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_mispredict   (ex_mispredict),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    gshare_predictor #(.CNT_W(2)) dut_small (
        .clk             (clk),
        .reset           (reset),
        .fetch_pc        (fetch_pc),
        .fetch_is_branch (fetch_is_branch),
        .fetch_stall     (fetch_stall),
        .prediction      (s_prediction),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_mispredict   (ex_mispredict),
        .branch_cnt      (s_branch_cnt),
        .mispredict_cnt  (s_mispredict_cnt)
    );

    function automatic logic m_pred();
        int idx;
        idx = int'(((fetch_pc >> 2) ^ m_gs) & 32'hFF);
        return fetch_is_branch && (m_pht[idx] >= 2);
    endfunction

    task automatic set_in(input logic [31:0] pc, input logic isb, input logic stall,
                          input logic exv, input logic [31:0] expc,
                          input logic ext, input logic exm);
        fetch_pc = pc; fetch_is_branch = isb; fetch_stall = stall;
        ex_valid = exv; ex_pc = expc; ex_taken = ext; ex_mispredict = exm;
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic tick();
        int   ie;
        int   ng;
        logic p;
        p = m_pred();
        if (reset) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 2;
            m_gs = 0; m_ga = 0; m_bc = 0; m_mc = 0;
        end else begin
            ng = m_ga;
            if (ex_valid) begin
                ie = int'(((ex_pc >> 2) ^ m_ga) & 32'hFF);
                if (ex_taken) m_pht[ie] = (m_pht[ie] == 3) ? 3 : m_pht[ie] + 1;
                else          m_pht[ie] = (m_pht[ie] == 0) ? 0 : m_pht[ie] - 1;
                ng = ((m_ga << 1) | int'(ex_taken)) & 255;
                if (m_bc < CNT_MAX) m_bc++;
                if (ex_mispredict && m_mc < CNT_MAX) m_mc++;
            end
            if (ex_valid && ex_mispredict) m_gs = ng;
            else if (fetch_is_branch && !fetch_stall) m_gs = ((m_gs << 1) | int'(p)) & 255;
            m_ga = ng;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++; if (prediction !== 1'b1) begin miscompares++; $display("FAIL reset_pred_branch got %0b want 1", prediction); end
        vectors++; if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_counters got %0h/%0h want 0/0", branch_cnt, mispredict_cnt); end
        vectors++; if (dut.ghr_spec !== 8'h0 || dut.ghr_arch !== 8'h0) begin miscompares++; $display("FAIL reset_ghr got %0h/%0h want 0/0", dut.ghr_spec, dut.ghr_arch); end
        fetch_is_branch = 1'b0;
        #1;
        vectors++; if (prediction !== 1'b0) begin miscompares++; $display("FAIL reset_pred_nonbranch got %0b want 0", prediction); end
    endtask

    task automatic test_train_down();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
            tick();
            set_in(32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            vectors++; if (prediction !== 1'b0) begin miscompares++; $display("FAIL train_down_%0d got %0b want 0", k, prediction); end
            tick();
        end
        vectors++; if (dut.ghr_arch !== 8'h0 || branch_cnt !== 32'd3) begin miscompares++; $display("FAIL train_down_state got ghr_arch=%0h cnt=%0d want 0/3", dut.ghr_arch, branch_cnt); end
    endtask

    task automatic test_spec_history();
        do_reset();
        set_in(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++; if (prediction !== 1'b1) begin miscompares++; $display("FAIL spec_pred0 got %0b want 1", prediction); end
        tick();
        set_in(32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++; if (prediction !== 1'b1) begin miscompares++; $display("FAIL spec_pred1 got %0b want 1", prediction); end
        tick();
        vectors++; if (dut.ghr_spec !== 8'h03) begin miscompares++; $display("FAIL spec_shift got %0h want 03", dut.ghr_spec); end
        set_in(32'h108, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        vectors++; if (dut.ghr_spec !== 8'h03) begin miscompares++; $display("FAIL spec_stall got %0h want 03", dut.ghr_spec); end
    endtask

    task automatic test_recovery();
        logic [2:0] outcomes;
        do_reset();
        outcomes = 3'b101;
        for (int k = 2; k >= 0; k--) begin
            set_in(32'h0, 1'b0, 1'b0, 1'b1, 32'h200, outcomes[k], 1'b0);
            tick();
        end
        vectors++; if (dut.ghr_arch !== 8'h05) begin miscompares++; $display("FAIL recov_arch got %0h want 05", dut.ghr_arch); end
        set_in(32'h300, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1);
        tick();
        vectors++; if (dut.ghr_spec !== 8'h0A || dut.ghr_arch !== 8'h0A) begin miscompares++; $display("FAIL recov_ghr got %0h/%0h want 0A/0A", dut.ghr_spec, dut.ghr_arch); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_in(32'h0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        tick();
        set_in(32'h80, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
        #1;
        vectors++; if (prediction !== 1'b0) begin miscompares++; $display("FAIL same_cycle_old got %0b want 0", prediction); end
        tick();
        set_in(32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++; if (prediction !== 1'b1) begin miscompares++; $display("FAIL same_cycle_new got %0b want 1", prediction); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(32'h0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
            tick();
        end
        vectors++; if (s_mispredict_cnt !== 2'd2) begin miscompares++; $display("FAIL sat_pre got %0d want 2", s_mispredict_cnt); end
        for (int k = 0; k < 2; k++) begin
            set_in(32'h0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1);
            tick();
        end
        vectors++; if (s_mispredict_cnt !== 2'd3 || s_branch_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_hold got %0d/%0d want 3/3", s_branch_cnt, s_mispredict_cnt); end
        vectors++; if (mispredict_cnt !== 32'd4 || branch_cnt !== 32'd4) begin miscompares++; $display("FAIL sat_wide got %0d/%0d want 4/4", branch_cnt, mispredict_cnt); end
        // ex_mispredict without ex_valid must not count
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 32'h44, 1'b0, 1'b1);
        tick();
        vectors++; if (mispredict_cnt !== 32'd4) begin miscompares++; $display("FAIL mp_unqualified got %0d want 4", mispredict_cnt); end
        // reset in the middle of a mispredict burst
        reset = 1'b1;
        set_in(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        set_in(32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vectors++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0 || s_mispredict_cnt !== 2'd0) begin miscompares++; $display("FAIL midreset_cnt got %0d/%0d/%0d want 0/0/0", branch_cnt, mispredict_cnt, s_mispredict_cnt); end
        vectors++; if (prediction !== 1'b1) begin miscompares++; $display("FAIL midreset_pht got %0b want 1", prediction); end
        vectors++; if (dut.ghr_spec !== 8'h0 || dut.ghr_arch !== 8'h0) begin miscompares++; $display("FAIL midreset_ghr got %0h/%0h want 0/0", dut.ghr_spec, dut.ghr_arch); end
    endtask

    task automatic test_random();
        int fails = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            set_in(32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 2) != 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0));
            #1;
            vectors++;
            if (prediction !== m_pred() || branch_cnt !== 32'(m_bc) || mispredict_cnt !== 32'(m_mc)
                || dut.ghr_spec !== 8'(m_gs) || dut.ghr_arch !== 8'(m_ga)) begin
                miscompares++;
                if (fails < 10)
                    $display("FAIL random_%0d got pred=%0b bc=%0d mc=%0d gs=%0h ga=%0h want pred=%0b bc=%0d mc=%0d gs=%0h ga=%0h",
                             n, prediction, branch_cnt, mispredict_cnt, dut.ghr_spec, dut.ghr_arch,
                             m_pred(), m_bc, m_mc, m_gs, m_ga);
                fails++;
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_train_down();
        test_spec_history();
        test_recovery();
        test_same_cycle();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
